// File: rtl/ad_capture_readout_if.sv
// ad_capture_readout_if: STM32 parallel bus shared with the DA parameter path.
//   CS       chip select, active low
//   WR_EN    write enable, active high
//   RD_EN    read enable, active high
//   ADDR     16-bit register address
//   DATA_IN  16-bit write data
//   DATA_OUT 16-bit registered read data
// master: bus host (STM32 / testbench); slave: FPGA register block.
interface ad_capture_readout_if;
    logic        CS;
    logic        WR_EN;
    logic        RD_EN;
    logic [15:0] ADDR;
    logic [15:0] DATA_IN;
    logic [15:0] DATA_OUT;

    modport master (
        output CS,
        output WR_EN,
        output RD_EN,
        output ADDR,
        output DATA_IN,
        input  DATA_OUT
    );

    modport slave (
        input  CS,
        input  WR_EN,
        input  RD_EN,
        input  ADDR,
        input  DATA_IN,
        output DATA_OUT
    );
endinterface

// File: rtl/ad_capture_readout.sv
// ad_capture_readout: ADC capture buffer with bus read-back.
// A start command captures 2^ADDR_W decimated ADC samples into on-chip RAM; the host then
// reads samples (auto-incrementing pointer), status and the decimation divider over the bus.
//   CLK_BASE  system clock, rising edge
//   RST_N     asynchronous active-low reset
//   AD_DATA   ADC sample, synchronous to CLK_BASE
//   bus       register bus (slave side), DATA_OUT registered with 2-cycle read latency
//   BUSY      high while capturing
//   DONE      high once a full block is captured
module ad_capture_readout #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned ADDR_W    = 10,
    parameter logic [15:0] ADDR_CTRL = 16'h0010,
    parameter logic [15:0] ADDR_STAT = 16'h0011,
    parameter logic [15:0] ADDR_DATA = 16'h0012,
    parameter logic [15:0] ADDR_DIV  = 16'h0013
) (
    input  logic                  CLK_BASE,
    input  logic                  RST_N,
    input  logic [DATA_W-1:0]     AD_DATA,
    ad_capture_readout_if.slave   bus,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int unsigned Depth = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PtrMax = '1;

    typedef enum logic [1:0] {StIdle, StCapture, StReady} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [15:0]       dcnt_q, dcnt_d;
    logic [15:0]       div_q, div_d;
    logic [15:0]       addr_q;
    logic [15:0]       data_out_q, data_out_d;
    logic              rs_q;
    logic              ram_we;

    logic [DATA_W-1:0] ram [Depth];
    logic [DATA_W-1:0] ram_q;

    logic ws, rs, rs_fall, ctrl_wr, do_start, do_abort;

    assign ws       = !bus.CS && bus.WR_EN;
    assign rs       = !bus.CS && bus.RD_EN && (bus.ADDR == ADDR_DATA);
    assign rs_fall  = rs_q && !rs;
    assign ctrl_wr  = ws && (bus.ADDR == ADDR_CTRL);
    // Abort (bit1) outranks start (bit0).
    assign do_abort = ctrl_wr && bus.DATA_IN[1];
    assign do_start = ctrl_wr && bus.DATA_IN[0] && !bus.DATA_IN[1];

    assign div_d = (ws && (bus.ADDR == ADDR_DIV)) ? bus.DATA_IN : div_q;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        dcnt_d  = dcnt_q;
        ram_we  = 1'b0;

        unique case (state_q)
            StIdle: state_d = StIdle;
            StCapture: begin
                if (dcnt_q == div_q) begin
                    ram_we = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    dcnt_d = '0;
                    if (wptr_q == PtrMax) begin
                        state_d = StReady;
                    end
                end else begin
                    dcnt_d = dcnt_q + 16'd1;
                end
            end
            StReady: begin
                // Advance once the host releases the read strobe.
                if (rs_fall) begin
                    rptr_d = rptr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Control writes override normal progress, including a coincident read advance.
        if (do_abort) begin
            state_d = StIdle;
            wptr_d  = wptr_q;
            rptr_d  = rptr_q;
            dcnt_d  = dcnt_q;
            ram_we  = 1'b0;
        end else if (do_start) begin
            state_d = StCapture;
            wptr_d  = '0;
            rptr_d  = '0;
            dcnt_d  = '0;
            ram_we  = 1'b0;
        end
    end

    assign BUSY = (state_q == StCapture);
    assign DONE = (state_q == StReady);

    // Read mux sits after the registered address so every source sees the same 2-cycle latency.
    always_comb begin
        data_out_d = '0;
        case (addr_q)
            ADDR_STAT: data_out_d = {14'b0, DONE, BUSY};
            ADDR_DATA: data_out_d[DATA_W-1:0] = ram_q;
            ADDR_DIV:  data_out_d = div_q;
            default:   data_out_d = '0;
        endcase
    end

    always_ff @(posedge CLK_BASE or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            rptr_q     <= '0;
            dcnt_q     <= '0;
            div_q      <= '0;
            addr_q     <= '0;
            data_out_q <= '0;
            rs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            dcnt_q     <= dcnt_d;
            div_q      <= div_d;
            addr_q     <= bus.ADDR;
            data_out_q <= data_out_d;
            rs_q       <= rs;
        end
    end

    // Sample RAM: contents are not reset.
    always_ff @(posedge CLK_BASE) begin
        if (ram_we) begin
            ram[wptr_q] <= AD_DATA;
        end
        ram_q <= ram[rptr_q];
    end

    assign bus.DATA_OUT = data_out_q;

endmodule

// File: tb/tb_ad_capture_readout.sv
// Directed bench for ad_capture_readout: reset, register read-back, full capture with DIV=0,
// restart/abort priority, decimation with DIV=3 and abort mid-capture.
module tb_ad_capture_readout;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned ADDR_W = 10;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [15:0] A_CTRL = 16'h0010;
    localparam logic [15:0] A_STAT = 16'h0011;
    localparam logic [15:0] A_DATA = 16'h0012;
    localparam logic [15:0] A_DIV  = 16'h0013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] ad_data;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;

    ad_capture_readout_if bus ();

    ad_capture_readout #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLK_BASE (clk),
        .RST_N    (rst_n),
        .AD_DATA  (ad_data),
        .bus      (bus),
        .BUSY     (busy),
        .DONE     (done)
    );

    always #5 clk = ~clk;

    // ADC ramp changes on the falling edge so it is stable at every rising edge.
    initial begin
        ad_data = '0;
        forever begin
            @(negedge clk);
            ad_data = ad_data + 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        bus.CS      = 1'b0;
        bus.WR_EN   = 1'b1;
        bus.ADDR    = addr;
        bus.DATA_IN = data;
        tick(1);
        bus.CS      = 1'b1;
        bus.WR_EN   = 1'b0;
    endtask

    task automatic read_reg(input logic [15:0] addr, output logic [15:0] val);
        bus.CS    = 1'b0;
        bus.RD_EN = 1'b1;
        bus.ADDR  = addr;
        tick(2);
        val       = bus.DATA_OUT;
        bus.CS    = 1'b1;
        bus.RD_EN = 1'b0;
    endtask

    // Hold the strobe 3 cycles, release, then allow one cycle for the pointer step.
    task automatic read_data(output logic [15:0] val);
        bus.CS    = 1'b0;
        bus.RD_EN = 1'b1;
        bus.ADDR  = A_DATA;
        tick(3);
        val       = bus.DATA_OUT;
        bus.CS    = 1'b1;
        bus.RD_EN = 1'b0;
        tick(1);
    endtask

    task automatic busy_len(output int cnt);
        cnt = 0;
        while (busy && cnt < 5000) begin
            cnt++;
            tick(1);
        end
    endtask

    initial begin
        logic [15:0]       v;
        logic [DATA_W-1:0] base;
        logic [DATA_W-1:0] e;
        int                cnt;

        bus.CS      = 1'b1;
        bus.WR_EN   = 1'b0;
        bus.RD_EN   = 1'b0;
        bus.ADDR    = '0;
        bus.DATA_IN = '0;
        rst_n       = 1'b1;
        #2 rst_n    = 1'b0;
        #10;
        check_eq("rst_data_out", 32'(bus.DATA_OUT), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        tick(1);

        // Reset in the middle of a capture.
        bus_write(A_CTRL, 16'h0001);
        check_eq("start_busy", 32'(busy), 32'h1);
        tick(20);
        read_reg(A_STAT, v);
        check_eq("stat_capture", 32'(v), 32'h0001);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_data_out", 32'(bus.DATA_OUT), 32'h0);
        check_eq("midrst_busy", 32'(busy), 32'h0);
        check_eq("midrst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        tick(1);
        read_reg(A_STAT, v);
        check_eq("stat_after_rst", 32'(v), 32'h0000);

        // Register read-back and unmapped addresses.
        bus_write(A_DIV, 16'hABCD);
        read_reg(A_DIV, v);
        check_eq("div_readback", 32'(v), 32'hABCD);
        read_reg(16'h0020, v);
        check_eq("unmapped_0020", 32'(v), 32'h0000);
        read_reg(16'h0014, v);
        check_eq("unmapped_0014", 32'(v), 32'h0000);

        // Full capture, DIV=0: first sample is the ramp value one edge after the start.
        bus_write(A_DIV, 16'h0000);
        bus_write(A_CTRL, 16'h0001);
        base = ad_data + 1'b1;
        busy_len(cnt);
        check_eq("div0_busy_cycles", 32'(cnt), 32'd1024);
        check_eq("div0_done", 32'(done), 32'h1);
        check_eq("div0_busy_low", 32'(busy), 32'h0);
        read_reg(A_STAT, v);
        check_eq("div0_stat", 32'(v), 32'h0002);
        for (int k = 0; k <= DEPTH; k++) begin
            read_data(v);
            e = base + DATA_W'(k % DEPTH);
            check_eq($sformatf("div0_sample%0d", k), 32'(v), {20'h0, e});
        end

        // Restart from READY clears the read pointer; abort+start together aborts.
        bus_write(A_CTRL, 16'h0001);
        base = ad_data + 1'b1;
        check_eq("restart_busy", 32'(busy), 32'h1);
        check_eq("restart_done", 32'(done), 32'h0);
        read_data(v);
        check_eq("restart_rptr0", 32'(v), {20'h0, base});
        bus_write(A_CTRL, 16'h0003);
        check_eq("prio_busy", 32'(busy), 32'h0);
        check_eq("prio_done", 32'(done), 32'h0);
        read_data(v);
        check_eq("prio_read0", 32'(v), {20'h0, base});
        read_data(v);
        check_eq("prio_read1", 32'(v), {20'h0, base});

        // Decimation, DIV=3: first sample four edges after start, then every fourth value.
        bus_write(A_DIV, 16'h0003);
        bus_write(A_CTRL, 16'h0001);
        base = ad_data + DATA_W'(4);
        busy_len(cnt);
        check_eq("div3_busy_cycles", 32'(cnt), 32'd4096);
        check_eq("div3_done", 32'(done), 32'h1);
        for (int k = 0; k < DEPTH; k++) begin
            read_data(v);
            e = base + DATA_W'(4 * k);
            check_eq($sformatf("div3_sample%0d", k), 32'(v), {20'h0, e});
        end

        // Abort at about sample 100: IDLE, and data reads do not move the pointer.
        bus_write(A_DIV, 16'h0000);
        bus_write(A_CTRL, 16'h0001);
        base = ad_data + 1'b1;
        tick(99);
        bus_write(A_CTRL, 16'h0002);
        check_eq("abort_busy", 32'(busy), 32'h0);
        check_eq("abort_done", 32'(done), 32'h0);
        read_reg(A_STAT, v);
        check_eq("abort_stat", 32'(v), 32'h0000);
        read_data(v);
        check_eq("abort_read0", 32'(v), {20'h0, base});
        read_data(v);
        check_eq("abort_read1", 32'(v), {20'h0, base});
        read_data(v);
        check_eq("abort_read2", 32'(v), {20'h0, base});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
